pipeline_foreground_fetch: RTL and testbench



---
 rtl/pipeline_pkg.sv | 13 +
 rtl/pipeline_valid_delay.sv | 33 +++
 rtl/pipeline_foreground_fetch.sv | 165 ++++++++++++++++
 tb/tb_pipeline_foreground_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the compositing pipeline blocks.
package pipeline_pkg;

    localparam int PIXEL_SIZE = 16;

    // Fixed fetch stages around the SRAM: S1, S2, address cycle, output register.
    localparam int FETCH_FIXED_STAGES = 4;

    function automatic int addr_width(input int res_x, input int res_y);
        return $clog2(res_x * res_y);
    endfunction

endpackage

// File: rtl/pipeline_valid_delay.sv
// Valid/skip shift register with synchronous clear; every stage is visible.
module pipeline_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_skip,
    output logic [DEPTH-1:0] o_valid,
    output logic [DEPTH-1:0] o_skip
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_skip;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_valid <= '0;
            r_skip  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_skip[0]  <= i_skip;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_skip[k]  <= r_skip[k-1];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_skip  = r_skip;

endmodule

// File: rtl/pipeline_foreground_fetch.sv
// Foreground pixel fetch from the frame SRAM: fixed-latency read pipeline plus
// a lower-priority capture write port that only uses idle bus cycles.
module pipeline_foreground_fetch
    import pipeline_pkg::*;
#(
    parameter int R_WIDTH                      = 5,
    parameter int G_WIDTH                      = 6,
    parameter int B_WIDTH                      = 5,
    parameter int PRECISION                    = 11,
    parameter int RESOLUTION_X                 = 800,
    parameter int RESOLUTION_Y                 = 600,
    parameter int ADDR_WIDTH                   = 19,
    parameter int SRAM_READ_LATENCY            = 2,
    parameter int FOREGROUND_FETCH_CYCLE_DELAY = 6,
    localparam int PIX_W = R_WIDTH + G_WIDTH + B_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic                        req_active,
    input  logic signed [PRECISION:0]   req_x,
    input  logic signed [PRECISION:0]   req_y,
    output logic [PIX_W-1:0]            fg_pixel_out,
    output logic                        fg_pixel_skip,
    output logic                        fg_pixel_ready,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic                        sram_we,
    output logic                        sram_oe,
    output logic [PIX_W-1:0]            sram_wdata,
    output logic                        sram_wdata_en,
    input  logic [PIX_W-1:0]            sram_rdata,
    input  logic                        wr_valid,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [PIX_W-1:0]            wr_data,
    output logic                        wr_ready
);

    localparam int L = SRAM_READ_LATENCY;
    localparam logic signed [PRECISION:0] LP_RES_X   = RESOLUTION_X[PRECISION:0];
    localparam logic signed [PRECISION:0] LP_RES_Y   = RESOLUTION_Y[PRECISION:0];
    localparam logic [ADDR_WIDTH-1:0]     LP_ROW_MUL = RESOLUTION_X[ADDR_WIDTH-1:0];

    if (FOREGROUND_FETCH_CYCLE_DELAY != FETCH_FIXED_STAGES + SRAM_READ_LATENCY) begin : g_bad_delay
        $error("FOREGROUND_FETCH_CYCLE_DELAY must equal 4 + SRAM_READ_LATENCY");
    end
    if (ADDR_WIDTH < addr_width(RESOLUTION_X, RESOLUTION_Y)) begin : g_bad_addr
        $error("ADDR_WIDTH too small for the frame");
    end
    if (SRAM_READ_LATENCY < 1) begin : g_bad_latency
        $error("SRAM_READ_LATENCY must be at least 1");
    end

    logic                     w_skip_in;
    logic                     r_s1_valid, r_s1_skip;
    logic signed [PRECISION:0] r_s1_x, r_s1_y;
    logic                     r_s2_valid, r_s2_skip;
    logic signed [PRECISION:0] r_s2_x;
    logic [ADDR_WIDTH-1:0]    r_s2_row;
    logic                     w_s1_rd, w_s2_rd;
    logic [ADDR_WIDTH-1:0]    w_row, w_addr;
    logic [L:0]               w_line_valid, w_line_skip, w_inflight;
    logic                     w_resp_valid, w_resp_skip, w_wr_go;

    logic                     r_ready, r_skip, r_we, r_oe, r_wdata_en, r_wr_ready;
    logic [PIX_W-1:0]         r_pixel, r_wdata;
    logic [ADDR_WIDTH-1:0]    r_addr;

    assign w_skip_in = ~req_active | req_x[PRECISION] | req_y[PRECISION]
                     | (req_x >= LP_RES_X) | (req_y >= LP_RES_Y);

    assign w_s1_rd = r_s1_valid & ~r_s1_skip;
    assign w_s2_rd = r_s2_valid & ~r_s2_skip;
    assign w_row   = ADDR_WIDTH'($unsigned(r_s1_y)) * LP_ROW_MUL;
    assign w_addr  = r_s2_row + ADDR_WIDTH'($unsigned(r_s2_x));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_skip  <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_skip  <= 1'b0;
            r_s2_x     <= '0;
            r_s2_row   <= '0;
        end else begin
            r_s1_valid <= req_valid;
            r_s1_skip  <= w_skip_in;
            r_s1_x     <= req_x;
            r_s1_y     <= req_y;
            r_s2_valid <= r_s1_valid;
            r_s2_skip  <= r_s1_skip;
            r_s2_x     <= r_s1_x;
            r_s2_row   <= w_row;
        end
    end

    // Stage 0 runs alongside the address cycle, stage L alongside the data cycle;
    // the non-skip bits double as the in-flight read tracker.
    pipeline_valid_delay #(
        .DEPTH (L + 1)
    ) u_line (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_valid (r_s2_valid),
        .i_skip  (r_s2_skip),
        .o_valid (w_line_valid),
        .o_skip  (w_line_skip)
    );

    assign w_inflight   = w_line_valid & ~w_line_skip;
    assign w_resp_valid = w_line_valid[L];
    assign w_resp_skip  = w_line_skip[L];
    assign w_wr_go      = wr_valid & r_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_oe       <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wdata_en <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            // Registered ready looks one stage further back so it is exact next cycle.
            r_wr_ready <= ~(w_s1_rd | w_s2_rd | (|w_inflight));
            r_oe       <= w_s2_rd;
            r_we       <= 1'b0;
            r_wdata_en <= 1'b0;
            if (w_s2_rd) begin
                r_addr <= w_addr;
            end else if (w_wr_go) begin
                r_addr     <= wr_addr;
                r_we       <= 1'b1;
                r_wdata    <= wr_data;
                r_wdata_en <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_skip  <= 1'b0;
            r_pixel <= '0;
        end else begin
            r_ready <= w_resp_valid;
            r_skip  <= w_resp_valid & w_resp_skip;
            if (w_resp_valid) begin
                r_pixel <= w_resp_skip ? '0 : sram_rdata;
            end
        end
    end

    assign fg_pixel_out   = r_pixel;
    assign fg_pixel_skip  = r_skip;
    assign fg_pixel_ready = r_ready;
    assign sram_addr      = r_addr;
    assign sram_we        = r_we;
    assign sram_oe        = r_oe;
    assign sram_wdata     = r_wdata;
    assign sram_wdata_en  = r_wdata_en;
    assign wr_ready       = r_wr_ready;

endmodule

// File: tb/tb_pipeline_foreground_fetch.sv
// Bench for pipeline_foreground_fetch: SRAM model plus a queue-based reference
// of when each response, address cycle and write cycle must appear.
module tb_pipeline_foreground_fetch;

    localparam int RX  = 800;
    localparam int RY  = 600;
    localparam int LAT = 2;
    localparam int DLY = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid, req_active;
    logic signed [11:0] req_x, req_y;
    logic [15:0]        fg_pixel_out;
    logic               fg_pixel_skip, fg_pixel_ready;
    logic [18:0]        sram_addr;
    logic               sram_we, sram_oe, sram_wdata_en;
    logic [15:0]        sram_wdata, sram_rdata;
    logic               wr_valid, wr_ready;
    logic [18:0]        wr_addr;
    logic [15:0]        wr_data;

    pipeline_foreground_fetch #(
        .SRAM_READ_LATENCY            (LAT),
        .FOREGROUND_FETCH_CYCLE_DELAY (DLY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_active     (req_active),
        .req_x          (req_x),
        .req_y          (req_y),
        .fg_pixel_out   (fg_pixel_out),
        .fg_pixel_skip  (fg_pixel_skip),
        .fg_pixel_ready (fg_pixel_ready),
        .sram_addr      (sram_addr),
        .sram_we        (sram_we),
        .sram_oe        (sram_oe),
        .sram_wdata     (sram_wdata),
        .sram_wdata_en  (sram_wdata_en),
        .sram_rdata     (sram_rdata),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Frame SRAM contents: explicit writes, otherwise an address-derived pattern.
    logic [15:0] wmem [int];
    function automatic logic [15:0] mem_rd(input int a);
        if (wmem.exists(a)) return wmem[a];
        return 16'(a * 37) ^ 16'h5A3C;
    endfunction

    logic [15:0] d1;
    always @(posedge clk) begin
        if (sram_we === 1'b1) wmem[int'(sram_addr)] = sram_wdata;
        d1         <= (sram_oe === 1'b1) ? mem_rd(int'(sram_addr)) : 16'hDEAD;
        sram_rdata <= d1;
    end

    typedef struct { int due; logic skip; logic [15:0] pix; } resp_t;
    typedef struct { int due; int addr; logic [15:0] data; } bus_t;
    resp_t rq[$];
    bus_t  aq[$];
    bus_t  wq[$];
    logic  rst_q     = 1'b0;
    logic  burst_chk = 1'b0;
    int    last_rd   = -100;

    always @(negedge clk) if (cyc > 0) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("ready", fg_pixel_ready, 1);
            chk("skip", fg_pixel_skip, rq[0].skip);
            chk("pixel", fg_pixel_out, rq[0].pix);
            void'(rq.pop_front());
        end else begin
            chk("ready_idle", fg_pixel_ready, 0);
        end
        if (aq.size() > 0 && aq[0].due == cyc) begin
            chk("oe", sram_oe, 1);
            chk("rd_addr", sram_addr, aq[0].addr);
            void'(aq.pop_front());
        end else begin
            chk("oe_idle", sram_oe, 0);
        end
        if (wq.size() > 0 && wq[0].due == cyc) begin
            chk("we", sram_we, 1);
            chk("wdata_en", sram_wdata_en, 1);
            chk("wr_addr", sram_addr, wq[0].addr);
            chk("wdata", sram_wdata, wq[0].data);
            void'(wq.pop_front());
        end else begin
            chk("we_idle", sram_we, 0);
            chk("wdata_en_idle", sram_wdata_en, 0);
        end
        if (sram_wdata_en === 1'b1) chk("turnaround", (cyc - last_rd) > LAT, 1);
        if (sram_oe === 1'b1) last_rd = cyc;
        if (burst_chk) chk("burst_wr_ready", wr_ready, 0);
        if (rst_q) begin
            chk("rst_pixel", fg_pixel_out, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_wdata", sram_wdata, 0);
            chk("rst_skip", fg_pixel_skip, 0);
            chk("rst_wr_ready", wr_ready, 0);
        end

        if (rst) begin
            rq.delete();
            aq.delete();
            wq.delete();
        end else begin
            if (req_valid) begin
                int x, y, a;
                logic sk;
                x  = int'(req_x);
                y  = int'(req_y);
                sk = !req_active || x < 0 || y < 0 || x >= RX || y >= RY;
                a  = y * RX + x;
                rq.push_back('{due: cyc + DLY, skip: sk, pix: sk ? 16'h0 : mem_rd(a)});
                if (!sk) aq.push_back('{due: cyc + 3, addr: a, data: 16'h0});
            end
            if (wr_valid && wr_ready)
                wq.push_back('{due: cyc + 1, addr: int'(wr_addr), data: wr_data});
        end
        rst_q = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input int x, input int y, input logic act);
        req_valid  = 1'b1;
        req_active = act;
        req_x      = 12'(x);
        req_y      = 12'(y);
        step();
        req_valid  = 1'b0;
    endtask

    task automatic wait_accept();
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 3000 && !acc; k++) begin
            @(negedge clk);
            acc = wr_ready;
            step();
        end
        chk("wr_accept", acc, 1);
        wr_valid = 1'b0;
    endtask

    initial begin
        req_valid = 0; req_active = 0; req_x = 0; req_y = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        wmem[1610] = 16'hABCD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        send(10, 2, 1);
        idle(8);

        send(-1, 0, 1);
        send(800, 5, 1);
        send(5, 600, 1);
        send(3, 3, 0);
        idle(10);

        wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 16'h1234;
        wait_accept();
        idle(5);
        send(100, 0, 1);
        idle(8);

        for (int i = 0; i < RX; i++) begin
            req_valid = 1'b1; req_active = 1'b1;
            req_x = 12'(i); req_y = 12'(4);
            if (i == 2) begin
                burst_chk = 1'b1;
                wr_valid  = 1'b1; wr_addr = 19'd490000; wr_data = 16'h5A5A;
            end
            step();
        end
        req_valid = 1'b0;
        burst_chk = 1'b0;
        wait_accept();
        idle(10);

        send(20, 1, 1);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(10);

        repeat (400) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_active = ($urandom_range(0, 19) != 0);
            req_x      = 12'(int'($urandom_range(0, 840)) - 20);
            req_y      = 12'(int'($urandom_range(0, 610)) - 5);
            wr_valid   = ($urandom_range(0, 3) == 0);
            wr_addr    = 19'(480000 + $urandom_range(0, 40000));
            wr_data    = 16'($urandom);
            step();
        end
        wr_valid = 1'b0;
        idle(12);

        chk("drain_resp", rq.size(), 0);
        chk("drain_addr", aq.size(), 0);
        chk("drain_wr", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
